fetch_decode_stage: RTL
=======================

// Module: fetch_decode_stage
// PURPOSE
//  Instruction-fetch stage plus the F/D pipeline latch for the 5-stage processor.
//  - Owns the PC and drives address_imem.
//  - Captures q_imem into the F/D latch that feeds decode and the D/X stage.
//  - Detects load-use hazards against the instruction in D/X and stalls fetch.
//  - Accepts branch/jump redirects from X, which flush the latch.
// PARAMETERS
//  ADDR_W    12  imem word-address width; the PC wraps modulo 2^ADDR_W
//  DATA_W    32  instruction width
//  RESET_PC  0   PC value loaded on reset
//  CNT_W     16  width of the stall performance counter
// PORTS
//  clock          in   1       single clock; all state updates on posedge
//  reset          in   1       asynchronous, active-low (0 = reset asserted)
//  q_imem         in   DATA_W  instruction at address_imem; valid in the same cycle
//  address_imem   out  ADDR_W  current PC
//  ext_stall      in   1       stall from downstream (e.g. multdiv busy): hold PC and F/D
//  redirect       in   1       taken branch/jump resolved in X
//  redirect_pc    in   ADDR_W  target PC for redirect
//  dx_mem_read    in   1       instruction in D/X is lw
//  dx_rd          in   5       destination register of the D/X instruction
//  fd_insn        out  DATA_W  F/D latched instruction (all-zero = nop)
//  fd_pc_plus1    out  ADDR_W  PC+1 of fd_insn (for branch/jal arithmetic)
//  fd_valid       out  1       fd_insn is a real instruction
//  dx_bubble      out  1       D/X must load a nop this cycle
//  stall_count    out  CNT_W   saturating count of stalled cycles
// BEHAVIOUR
//  Reset (async, active-low, effective immediately, including mid-operation):
//   PC=RESET_PC; fd_insn=0; fd_pc_plus1=0; fd_valid=0; stall_count=0.
//   Combinational outputs follow from those values, so dx_bubble=0.
//  Instruction fields: opcode[31:27] rd[26:22] rs[21:17] rt[16:12].
//  Source-register use set, decoded from the fd_insn opcode:
//   00000 R-type -> rs, rt
//   00101 addi, 01000 lw -> rs
//   00111 sw, 00010 bne, 00110 blt -> rd, rs
//   00100 jr -> rd
//   all others -> none
//  Load-use hazard (combinational), when all of the following hold:
//   - fd_valid and dx_mem_read;
//   - dx_rd != 0;
//   - dx_rd matches a used source register of fd_insn.
//  stall = lu_hazard | ext_stall.
//  dx_bubble = lu_hazard & ~redirect.
//  Per posedge, in priority order:
//   1. redirect: PC <= redirect_pc; fd_insn <= 0; fd_valid <= 0; fd_pc_plus1 <= 0.
//      Redirect beats both stall sources.
//   2. stall: PC and the F/D latch all hold.
//   3. else: PC <= PC+1 (wraps 2^ADDR_W-1 -> 0); fd_insn <= q_imem;
//      fd_pc_plus1 <= PC+1 (wrapped); fd_valid <= 1.
//  stall_count increments when stall & ~redirect, saturating at 2^CNT_W-1.
//  Latency: fetch to F/D is 1 cycle. A redirect takes effect the next cycle
//   (1 bubble). A load-use hazard costs exactly 1 stall cycle, since D/X
//   then holds the bubble and dx_mem_read drops.
//  A q_imem value of 0 fetched while not stalled latches with fd_valid=1.
//   It is a legal nop.
// STRUCTURE
//  Package fetch_pkg:
//   - opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR);
//   - field bit positions;
//   - NOP constant (32'b0).
//  Sub-module load_use_detect: purely combinational;
//   inputs fd_insn, fd_valid, dx_mem_read, dx_rd; output lu_hazard.
//  Top level holds the PC register, the F/D latch, the counter and the priority mux.
// TESTING
//  T1 Reset low mid-run with PC=7 -> address_imem=0 and fd_valid=0 immediately;
//     after release, PC counts 0,1,2.
//  T2 Straight-line: q_imem = add $3,$1,$2 at PC 0 -> next cycle fd_insn holds it,
//     fd_pc_plus1=1, fd_valid=1, address_imem=1.
//  T3 Load-use: dx_mem_read=1, dx_rd=1, fd_insn = add $3,$1,$2
//     -> dx_bubble=1, PC/F/D held for 1 cycle, stall_count=1.
//     Repeat with dx_rd=0 -> no stall.
//  T4 Redirect while ext_stall=1 and lu_hazard=1: redirect_pc=12'h040
//     -> next cycle address_imem=12'h040, fd_valid=0, dx_bubble=0, stall_count unchanged.
//  T5 sw $5,0($6) in F/D with dx_rd=5, dx_mem_read=1 -> stall (rd used).
//     addi $5,$7,1 with dx_rd=5 -> no stall (rd not a source).
//  T6 PC wrap: start at 12'hFFF, no stall -> address_imem=0, fd_pc_plus1=0.
//     Force 2^CNT_W stall cycles -> stall_count holds at all-ones.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// Purpose: shared opcodes, instruction field positions and source-register decode for fetch/decode.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package fetch_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;

  localparam logic [31:0] NOP = 32'b0;

  // Which register fields an instruction reads as sources.
  typedef struct packed {
    logic rd;
    logic rs;
    logic rt;
  } src_use_t;

  function automatic src_use_t decode_src_use(input logic [4:0] opcode);
    src_use_t u;
    u = '0;
    case (opcode)
      OP_RTYPE:              begin u.rs = 1'b1; u.rt = 1'b1; end
      OP_ADDI, OP_LW:        begin u.rs = 1'b1; end
      // Stores and compares read rd as a data/compare source, not a destination.
      OP_SW, OP_BNE, OP_BLT: begin u.rd = 1'b1; u.rs = 1'b1; end
      OP_JR:                 begin u.rd = 1'b1; end
      default:               u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Purpose: bundles the imem, redirect, hazard and F/D output signals of the fetch stage.
// Latency: n/a (wiring only).
// Backpressure: stall inputs (ext_stall, load-use) hold the stage; redirect overrides.
// Ports (slave = the stage): q_imem, ext_stall, redirect, redirect_pc, dx_mem_read, dx_rd in;
//   address_imem, fd_insn, fd_pc_plus1, fd_valid, dx_bubble, stall_count out.
interface fetch_decode_stage_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] q_imem;
  logic [ADDR_W-1:0] address_imem;
  logic              ext_stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              dx_mem_read;
  logic [4:0]        dx_rd;
  logic [DATA_W-1:0] fd_insn;
  logic [ADDR_W-1:0] fd_pc_plus1;
  logic              fd_valid;
  logic              dx_bubble;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output q_imem, ext_stall, redirect, redirect_pc, dx_mem_read, dx_rd,
    input  address_imem, fd_insn, fd_pc_plus1, fd_valid, dx_bubble, stall_count
  );

  modport slave (
    input  q_imem, ext_stall, redirect, redirect_pc, dx_mem_read, dx_rd,
    output address_imem, fd_insn, fd_pc_plus1, fd_valid, dx_bubble, stall_count
  );
endinterface

// File: rtl/fetch_decode_stage_load_use_detect.sv
// Purpose: flags a load-use hazard between the F/D instruction and a lw sitting in D/X.
// Latency: combinational.
// Backpressure: its output is one of the two stall sources of the fetch stage.
// Ports: fd_insn_i, fd_valid_i, dx_mem_read_i, dx_rd_i in; lu_hazard_o out.
module load_use_detect
  import fetch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] fd_insn_i,
  input  logic              fd_valid_i,
  input  logic              dx_mem_read_i,
  input  logic [4:0]        dx_rd_i,
  output logic              lu_hazard_o
);

  src_use_t   src_use;
  logic [4:0] f_rd;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic       src_hit;
  logic       unused_low_bits;

  assign src_use = decode_src_use(fd_insn_i[OPC_HI:OPC_LO]);
  assign f_rd    = fd_insn_i[RD_HI:RD_LO];
  assign f_rs    = fd_insn_i[RS_HI:RS_LO];
  assign f_rt    = fd_insn_i[RT_HI:RT_LO];

  // Immediate/shamt bits never name a register.
  assign unused_low_bits = ^fd_insn_i[RT_LO-1:0];

  assign src_hit = (src_use.rd && (f_rd == dx_rd_i)) ||
                   (src_use.rs && (f_rs == dx_rd_i)) ||
                   (src_use.rt && (f_rt == dx_rd_i));

  // $0 is hardwired zero, so a lw targeting it never produces a value to wait for.
  assign lu_hazard_o = fd_valid_i && dx_mem_read_i && (dx_rd_i != 5'd0) && src_hit;

endmodule

// File: rtl/fetch_decode_stage.sv
// Purpose: PC register, F/D pipeline latch, stall counter and redirect/stall priority mux.
// Latency: fetch to F/D is 1 cycle; redirect costs 1 bubble; load-use costs 1 stall cycle.
// Backpressure: ext_stall or load-use holds PC and F/D; redirect beats both and flushes F/D.
// Ports: clock, reset (async active-low) plain; everything else via fetch_decode_stage_if.slave.
module fetch_decode_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input logic                  clock,
  input logic                  reset,
  fetch_decode_stage_if.slave  bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] fd_insn_q, fd_insn_d;
  logic [ADDR_W-1:0] fd_pc_plus1_q, fd_pc_plus1_d;
  logic              fd_valid_q, fd_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [ADDR_W-1:0] pc_plus1;
  logic              lu_hazard;
  logic              stall;

  load_use_detect #(.DATA_W(DATA_W)) u_lud (
    .fd_insn_i     (fd_insn_q),
    .fd_valid_i    (fd_valid_q),
    .dx_mem_read_i (bus.dx_mem_read),
    .dx_rd_i       (bus.dx_rd),
    .lu_hazard_o   (lu_hazard)
  );

  // Natural ADDR_W-bit overflow gives the required modulo-2^ADDR_W wrap.
  assign pc_plus1 = pc_q + ADDR_W'(1);
  assign stall    = lu_hazard | bus.ext_stall;

  always_comb begin
    pc_d          = pc_q;
    fd_insn_d     = fd_insn_q;
    fd_pc_plus1_d = fd_pc_plus1_q;
    fd_valid_d    = fd_valid_q;
    stall_cnt_d   = stall_cnt_q;

    if (bus.redirect) begin
      pc_d          = bus.redirect_pc;
      fd_insn_d     = DATA_W'(NOP);
      fd_pc_plus1_d = '0;
      fd_valid_d    = 1'b0;
    end else if (stall) begin
      // Hold everything; only the performance counter moves.
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      pc_d          = pc_plus1;
      fd_insn_d     = bus.q_imem;
      fd_pc_plus1_d = pc_plus1;
      fd_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      fd_insn_q     <= '0;
      fd_pc_plus1_q <= '0;
      fd_valid_q    <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      fd_insn_q     <= fd_insn_d;
      fd_pc_plus1_q <= fd_pc_plus1_d;
      fd_valid_q    <= fd_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.address_imem = pc_q;
  assign bus.fd_insn      = fd_insn_q;
  assign bus.fd_pc_plus1  = fd_pc_plus1_q;
  assign bus.fd_valid     = fd_valid_q;
  // The bubble is only needed when the stalled F/D instruction survives the cycle.
  assign bus.dx_bubble    = lu_hazard & ~bus.redirect;
  assign bus.stall_count  = stall_cnt_q;

endmodule
